pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised next-generation program counter for the single-cycle core.
- Generalises the fixed 64-bit PC/branch-on-zero block to configurable XLEN and reset vector.
- Adds full branch-condition decode, JAL/JALR, stall, a trap/return path with saved EPC, misaligned-target detection and a retired-instruction counter.
- Sits between the control unit/ALU flags and instruction memory; pc_current drives the fetch address.

Parameters:
XLEN, 64, PC/data width in bits (32 or 64)
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 'h100, PC loaded when a trap is taken
CNT_W, 64, width of the instret counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
stall  in  1  hold PC, EPC, counter this cycle
branch  in  1  conditional branch instruction
branch_cond  in  3  condition code (pc_pkg encoding)
zero  in  1  ALU result == 0
lt  in  1  ALU signed less-than
ltu  in  1  ALU unsigned less-than
jump  in  1  JAL: target = pc + imm
jump_reg  in  1  JALR: target = (rs1 + imm) & ~1
rs1  in  XLEN  JALR base register value
imm  in  XLEN  sign-extended immediate (byte offset)
trap  in  1  external trap request
mret  in  1  return from trap: PC <- EPC
pc_current  out  XLEN  registered fetch address
pc_next  out  XLEN  combinational next PC
pc_plus4  out  XLEN  pc_current + 4 (link value)
taken  out  1  redirect this cycle (branch taken, jump, jump_reg, trap or mret)
epc  out  XLEN  saved exception PC
cause  out  2  last trap cause (0 none, 1 external, 2 misaligned target)
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: clock edge with reset==0 sets pc_current=RESET_VECTOR, epc=0, cause=0, instret=0. Reset overrides stall and all requests.
- pc_next priority, highest first:
  - stall: pc_current
  - trap: TRAP_VECTOR
  - mret: epc
  - jump_reg: (rs1+imm)&~1
  - jump: pc+imm
  - branch taken: pc+imm
  - otherwise pc_plus4
- Branch conditions:
  - BEQ 000: zero
  - BNE 001: !zero
  - BLT 100: lt
  - BGE 101: !lt
  - BLTU 110: ltu
  - BGEU 111: !ltu
  - Codes 010 and 011: never taken.
- Arithmetic: all adds are modulo 2^XLEN; wrap-around is silent (pc=max-3 +4 -> 0).
- Misaligned target: a selected jump, jump_reg or taken-branch target with bits[1:0]!=0 converts to a trap. pc_next=TRAP_VECTOR, epc<=pc_current, cause<=2.
- External trap: epc<=pc_current, cause<=1. Trap and mret in the same cycle: trap wins and epc is overwritten.
- taken = !stall && (pc_next != pc_plus4 due to a redirect source). A taken branch whose target equals pc+4 still asserts taken.
- Latency: pc_next is combinational; pc_current updates on the next rising edge, one cycle.
- Counter: instret increments by 1 on every non-stalled, non-reset edge where no trap (external or misaligned) is taken. mret counts. The counter wraps at 2^CNT_W.
- Stall: every register holds, taken=0. Trap/branch inputs asserted during stall are ignored, not queued.
- Reset mid-sequence: pending trap/jump inputs are discarded; the first post-reset edge without reset advances from RESET_VECTOR.

Decomposition:
- Package pc_pkg:
  - branch_cond localparams: BEQ, BNE, BLT, BGE, BLTU, BGEU
  - cause codes: CAUSE_NONE, CAUSE_EXT, CAUSE_MISALIGN
  - width of branch_cond and cause
- Sub-module branch_resolve: combinational; inputs branch_cond, zero, lt, ltu; output cond_true. pc_unit instantiates it once.

Test Plan:
- Release reset after 2 edges, no controls -> pc_current 0,4,8,12 on successive edges; instret=3 after the third edge.
- pc=12, branch=1, cond=BEQ, imm=16, zero=0 -> pc=16, taken=0; then zero=1 -> pc=32, taken=1.
- pc=32, branch=1, cond=BLTU, ltu=1, imm=-8 -> pc=24; cond=BGE with lt=1 -> pc=28.
- jump_reg=1, rs1=0x201, imm=2 -> target 0x202 misaligned -> pc=0x100, epc=previous pc, cause=2, instret unchanged; then mret=1 -> pc=epc.
- trap=1 and mret=1 together at pc=0x40 -> pc=0x100, epc=0x40, cause=1; stall=1 with jump=1 for 3 cycles -> pc, instret constant, taken=0.
- XLEN=32 instance with pc=0xFFFFFFFC, no controls -> pc=0; reset=0 asserted during jump=1 -> pc=RESET_VECTOR, instret=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter block: branch condition codes and trap causes.
package pc_pkg;

    localparam int unsigned BR_COND_W = 3;
    localparam int unsigned CAUSE_W   = 2;

    localparam logic [BR_COND_W-1:0] BEQ  = 3'b000;
    localparam logic [BR_COND_W-1:0] BNE  = 3'b001;
    localparam logic [BR_COND_W-1:0] BLT  = 3'b100;
    localparam logic [BR_COND_W-1:0] BGE  = 3'b101;
    localparam logic [BR_COND_W-1:0] BLTU = 3'b110;
    localparam logic [BR_COND_W-1:0] BGEU = 3'b111;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_EXT      = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'd2;

endpackage

// File: rtl/branch_resolve.sv
// Decodes a branch condition code against the ALU flags.
module branch_resolve
    import pc_pkg::*;
(
    input  logic [BR_COND_W-1:0] branch_cond,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    output logic                 cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (branch_cond)
            BEQ:     cond_true = zero;
            BNE:     cond_true = !zero;
            BLT:     cond_true = lt;
            BGE:     cond_true = !lt;
            BLTU:    cond_true = ltu;
            BGEU:    cond_true = !ltu;
            default: cond_true = 1'b0; // 010/011 are reserved, never taken
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump redirect, trap/mret path, saved EPC and retired count.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned     CNT_W        = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch,
    input  logic [BR_COND_W-1:0] branch_cond,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 jump,
    input  logic                 jump_reg,
    input  logic [XLEN-1:0]      rs1,
    input  logic [XLEN-1:0]      imm,
    input  logic                 trap,
    input  logic                 mret,
    output logic [XLEN-1:0]      pc_current,
    output logic [XLEN-1:0]      pc_next,
    output logic [XLEN-1:0]      pc_plus4,
    output logic                 taken,
    output logic [XLEN-1:0]      epc,
    output logic [CAUSE_W-1:0]   cause,
    output logic [CNT_W-1:0]     instret
);

    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [CNT_W-1:0]   instret_q;

    logic            cond_true;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] reg_target;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            misaligned;
    logic            trap_take;

    branch_resolve u_branch_resolve (
        .branch_cond(branch_cond),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .cond_true  (cond_true)
    );

    always_comb begin
        pc_plus4   = pc_q + XLEN'(4);
        rel_target = pc_q + imm;
        reg_target = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        redirect   = jump_reg | jump | (branch & cond_true);
        target     = jump_reg ? reg_target : rel_target;
        misaligned = redirect && (target[1:0] != 2'b00);
        // A misaligned target only matters when no higher-priority trap or mret wins.
        trap_take  = !stall && (trap || (!mret && misaligned));

        if (stall) begin
            pc_next = pc_q;
        end else if (trap_take) begin
            pc_next = TRAP_VECTOR;
        end else if (mret) begin
            pc_next = epc_q;
        end else if (redirect) begin
            pc_next = target;
        end else begin
            pc_next = pc_plus4;
        end

        taken = !stall && (trap || mret || redirect);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else if (!stall) begin
            pc_q <= pc_next;
            if (trap_take) begin
                epc_q   <= pc_q;
                cause_q <= trap ? CAUSE_EXT : CAUSE_MISALIGN;
            end else begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign pc_current = pc_q;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign instret    = instret_q;

endmodule
